cla_nibble_sequencer: RTL

Multi-cycle wide-add initiator that drives the registered 4-bit carry-lookahead adder slice (`toplevel`: x, y, cin in; z, cout out) one nibble at a time. It accepts a WIDTH-bit operand pair on a start pulse, issues nibbles LSB-first, and chains each captured `cout` into the next nibble's `cin`. It returns the full sum, carry and signed overflow with a one-cycle `done` pulse. It sits between the datapath controller and the adder slice, on the operand-driving side of the slice interface.

---
 rtl/cla_seq_pkg.sv | 21 ++
 rtl/cla_nibble_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead sequencer.
package cla_seq_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Drives an external registered 4-bit CLA slice nibble-by-nibble (LSB first) to form a WIDTH-bit add.
// Optional subtract path is built only when CLA_SEQ_SUB_EN is defined.
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_i,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic [3:0]       x,
  output logic [3:0]       y,
  output logic             cin,
  input  logic [3:0]       z,
  input  logic             cout
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int KW = clog2(N);
  localparam int CW = clog2(LAT + 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c0_q, chain_q, carry_q, ovf_q;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             accept, last_wait, last_nib;

`ifdef CLA_SEQ_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin_i;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff = b;
  assign c0    = cin_i;
`endif

  // Start is only sampled while not busy, so it is also taken in DONE.
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_wait = (state_q == WAIT) && (cnt_q == CW'(LAT - 1));
  assign last_nib  = (k_q == KW'(N - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? ISSUE : IDLE;
      ISSUE:      state_d = WAIT;
      WAIT:       if (last_wait) state_d = last_nib ? DONE : ISSUE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff;
      c0_q    <= c0;
      k_q     <= '0;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      if (last_wait) begin
        sum_q[NIBBLE*k_q +: NIBBLE] <= z;
        chain_q <= cout;
        if (last_nib) begin
          carry_q <= cout;
          // z[3] is the result MSB on the final nibble.
          ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (z[3] != a_q[WIDTH-1]);
        end else begin
          k_q <= k_q + KW'(1);
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    x    = '0;
    y    = '0;
    cin  = 1'b0;
    case (state_q)
      ISSUE, WAIT: begin
        busy = 1'b1;
        x    = a_q[NIBBLE*k_q +: NIBBLE];
        y    = b_q[NIBBLE*k_q +: NIBBLE];
        cin  = (k_q == '0) ? c0_q : chain_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sum   = sum_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule
